// File: rtl/wb_select_stage.sv
// MEM/WB pipeline register for the MIPS datapath: picks the write-back destination and data,
// extracts sub-word loads, and flags illegal selects or misaligned loads.
module wb_select_stage #(
    parameter int  DW       = 32,
    parameter int  AW       = 5,
    parameter int  LINK_REG = 31,
    localparam int LANES    = DW / 8,
    localparam int LW       = $clog2(LANES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          in_valid,
    input  logic          reg_write,
    input  logic [1:0]    reg_dst,
    input  logic [AW-1:0] rt,
    input  logic [AW-1:0] rd,
    input  logic [1:0]    mem_to_reg,
    input  logic [2:0]    ld_mode,
    input  logic [LW-1:0] addr_lo,
    input  logic [DW-1:0] alu_out,
    input  logic [DW-1:0] dm_out,
    input  logic [DW-1:0] dpc,
    output logic          out_valid,
    output logic          wb_we,
    output logic [AW-1:0] wb_addr,
    output logic [DW-1:0] wb_data,
    output logic          sel_err
);

    function automatic logic [DW-1:0] sext8(input logic [7:0] b);
        return {{(DW-8){b[7]}}, b};
    endfunction

    function automatic logic [DW-1:0] sext16(input logic [15:0] h);
        return {{(DW-16){h[15]}}, h};
    endfunction

    logic [AW-1:0] dest_s;
    logic          dst_err_s;
    logic [7:0]    byte_s;
    logic [15:0]   half_s;
    logic [DW-1:0] ld_data_s;
    logic          ld_err_s;
    logic [DW-1:0] data_s;
    logic          data_err_s;
    logic          err_s;

    logic          valid_d, valid_q;
    logic          we_d,    we_q;
    logic [AW-1:0] addr_d,  addr_q;
    logic [DW-1:0] data_d,  data_q;
    logic          err_d,   err_q;

    // Destination register selection
    always_comb begin
        dest_s    = {AW{1'b0}};
        dst_err_s = 1'b0;
        case (reg_dst)
            2'b00:   dest_s = rt;
            2'b01:   dest_s = rd;
            2'b10:   dest_s = AW'(LINK_REG);
            default: dst_err_s = 1'b1;
        endcase
    end

    assign byte_s = 8'(dm_out >> {addr_lo, 3'b000});
    assign half_s = 16'(dm_out >> {addr_lo[LW-1:1], 4'b0000});

    // Sub-word load extraction; faulty loads pass the raw word through
    always_comb begin
        ld_data_s = dm_out;
        ld_err_s  = 1'b0;
        case (ld_mode)
            3'b000: begin
                if (addr_lo != {LW{1'b0}}) ld_err_s = 1'b1;
                else                       ld_data_s = dm_out;
            end
            3'b001: ld_data_s = sext8(byte_s);
            3'b010: ld_data_s = {{(DW-8){1'b0}}, byte_s};
            3'b011: begin
                if (addr_lo[0]) ld_err_s = 1'b1;
                else            ld_data_s = sext16(half_s);
            end
            3'b100: begin
                if (addr_lo[0]) ld_err_s = 1'b1;
                else            ld_data_s = {{(DW-16){1'b0}}, half_s};
            end
            default: ld_err_s = 1'b1;
        endcase
    end

    // Write-back data source selection
    always_comb begin
        data_s     = alu_out;
        data_err_s = 1'b0;
        case (mem_to_reg)
            2'b00: data_s = alu_out;
            2'b01: begin
                data_s     = ld_data_s;
                data_err_s = ld_err_s;
            end
            2'b10:   data_s = dpc;
            default: data_err_s = 1'b1;
        endcase
    end

    assign err_s = in_valid & reg_write & (dst_err_s | data_err_s);

    // Next-state: flush beats stall, stall beats capture
    always_comb begin
        valid_d = valid_q;
        we_d    = we_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        if (flush) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
            addr_d  = {AW{1'b0}};
            data_d  = {DW{1'b0}};
            err_d   = 1'b0;
        end else if (stall) begin
            valid_d = valid_q;
            we_d    = we_q;
            addr_d  = addr_q;
            data_d  = data_q;
            err_d   = err_q;
        end else begin
            valid_d = in_valid;
            err_d   = err_s;
            we_d    = in_valid & reg_write & ~err_s & (dest_s != {AW{1'b0}});
            // Address and data track the last valid instruction even when no write occurs
            if (in_valid) begin
                addr_d = dest_s;
                data_d = data_s;
            end else begin
                addr_d = addr_q;
                data_d = data_q;
            end
        end
    end

    // Output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= {AW{1'b0}};
            data_q  <= {DW{1'b0}};
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign wb_we     = we_q;
    assign wb_addr   = addr_q;
    assign wb_data   = data_q;
    assign sel_err   = err_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// Bench for wb_select_stage: directed vector table, hand-written stall/flush/reset sequences,
// and randomized traffic checked against an arithmetic reference model.
module tb_wb_select_stage;

    typedef struct packed {
        logic        rst, stall, flush, iv, rw;
        logic [1:0]  rdst;
        logic [4:0]  rt, rd;
        logic [1:0]  m2r;
        logic [2:0]  ld;
        logic [1:0]  alo;
        logic [31:0] alu, dm, dpc;
    } in_t;

    typedef struct packed {
        logic        v, we, err;
        logic [4:0]  addr;
        logic [31:0] data;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid, reg_write;
    logic [1:0]  reg_dst, mem_to_reg, addr_lo;
    logic [4:0]  rt, rd;
    logic [2:0]  ld_mode;
    logic [31:0] alu_out, dm_out, dpc;
    logic        out_valid, wb_we, sel_err;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int   tests = 0;
    int   fails = 0;
    out_t model;
    vec_t tbl[$];

    always #5 clk = ~clk;

    wb_select_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .reg_write(reg_write), .reg_dst(reg_dst),
        .rt(rt), .rd(rd), .mem_to_reg(mem_to_reg), .ld_mode(ld_mode),
        .addr_lo(addr_lo), .alu_out(alu_out), .dm_out(dm_out), .dpc(dpc),
        .out_valid(out_valid), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .sel_err(sel_err)
    );

    function automatic in_t mk(logic r, logic s, logic f, logic iv, logic rw, logic [1:0] rdst,
                               logic [4:0] rtv, logic [4:0] rdv, logic [1:0] m2r, logic [2:0] ld,
                               logic [1:0] alo, logic [31:0] alu, logic [31:0] dm, logic [31:0] pc);
        in_t x;
        x.rst = r; x.stall = s; x.flush = f; x.iv = iv; x.rw = rw; x.rdst = rdst;
        x.rt = rtv; x.rd = rdv; x.m2r = m2r; x.ld = ld; x.alo = alo;
        x.alu = alu; x.dm = dm; x.dpc = pc;
        return x;
    endfunction

    function automatic out_t eo(logic v, logic we, logic err, logic [4:0] a, logic [31:0] d);
        out_t x;
        x.v = v; x.we = we; x.err = err; x.addr = a; x.data = d;
        return x;
    endfunction

    // Reference model: next visible outputs from the current ones and the sampled inputs
    function automatic out_t model_next(in_t i, out_t c);
        int unsigned b, h;
        bit          e;
        logic [4:0]  dst;
        logic [31:0] d;
        if (i.rst || i.flush) return eo(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        if (i.stall) return c;
        e = 1'b0;
        case (i.rdst)
            2'd0:    dst = i.rt;
            2'd1:    dst = i.rd;
            2'd2:    dst = 5'd31;
            default: begin dst = 5'd0; e = 1'b1; end
        endcase
        b = (i.dm >> (8 * i.alo)) & 32'hFF;
        h = (i.dm >> (16 * (i.alo / 2))) & 32'hFFFF;
        d = i.dm;
        case (i.m2r)
            2'd0: d = i.alu;
            2'd2: d = i.dpc;
            2'd3: begin d = i.alu; e = 1'b1; end
            default: begin
                case (i.ld)
                    3'd0: if (i.alo != 0) e = 1'b1;
                    3'd1: d = (b >= 128) ? b - 256 : b;
                    3'd2: d = b;
                    3'd3: if (i.alo % 2 != 0) e = 1'b1; else d = (h >= 32768) ? h - 65536 : h;
                    3'd4: if (i.alo % 2 != 0) e = 1'b1; else d = h;
                    default: e = 1'b1;
                endcase
            end
        endcase
        e = e && i.iv && i.rw;
        return eo(i.iv, i.iv && i.rw && !e && dst != 0, e,
                  i.iv ? dst : c.addr, i.iv ? d : c.data);
    endfunction

    task automatic drive(in_t i);
        rst = i.rst; stall = i.stall; flush = i.flush; in_valid = i.iv; reg_write = i.rw;
        reg_dst = i.rdst; rt = i.rt; rd = i.rd; mem_to_reg = i.m2r; ld_mode = i.ld;
        addr_lo = i.alo; alu_out = i.alu; dm_out = i.dm; dpc = i.dpc;
    endtask

    task automatic check(string nm, out_t e);
        tests++;
        if ({out_valid, wb_we, sel_err, wb_addr, wb_data} !== e) begin
            fails++;
            $display("FAIL %s: got v=%b we=%b err=%b addr=%0d data=%h, expected v=%b we=%b err=%b addr=%0d data=%h",
                     nm, out_valid, wb_we, sel_err, wb_addr, wb_data, e.v, e.we, e.err, e.addr, e.data);
        end
    endtask

    task automatic step(string nm, in_t i, out_t e);
        drive(i);
        @(posedge clk);
        model = model_next(i, model);
        #1;
        check(nm, e);
    endtask

    localparam logic [31:0] DM = 32'h80FF_7F01;

    initial begin
        in_t  ri;
        out_t re;
        drive(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 2'd0, 3'd0, 2'd0, 32'd0, 32'd0, 32'd0));
        model = eo(1'b0, 1'b0, 1'b0, 5'd0, 32'd0);

        tbl.push_back({mk(1,0,0,1,1,2'd1,5'd0,5'd9,2'd0,3'd0,2'd0,32'h1234,32'd0,32'd0), eo(0,0,0,5'd0,32'd0)});
        tbl.push_back({mk(1,0,0,1,1,2'd1,5'd0,5'd9,2'd0,3'd0,2'd0,32'h1234,32'd0,32'd0), eo(0,0,0,5'd0,32'd0)});
        tbl.push_back({mk(0,0,0,1,1,2'd1,5'd0,5'd9,2'd0,3'd0,2'd0,32'h1234,32'd0,32'd0), eo(1,1,0,5'd9,32'h0000_1234)});
        tbl.push_back({mk(0,0,0,1,1,2'd1,5'd0,5'd10,2'd1,3'd1,2'd0,32'd0,DM,32'd0), eo(1,1,0,5'd10,32'h0000_0001)});
        tbl.push_back({mk(0,0,0,1,1,2'd1,5'd0,5'd10,2'd1,3'd1,2'd2,32'd0,DM,32'd0), eo(1,1,0,5'd10,32'hFFFF_FFFF)});
        tbl.push_back({mk(0,0,0,1,1,2'd1,5'd0,5'd10,2'd1,3'd2,2'd3,32'd0,DM,32'd0), eo(1,1,0,5'd10,32'h0000_0080)});
        tbl.push_back({mk(0,0,0,1,1,2'd1,5'd0,5'd10,2'd1,3'd3,2'd2,32'd0,DM,32'd0), eo(1,1,0,5'd10,32'hFFFF_80FF)});
        tbl.push_back({mk(0,0,0,1,1,2'd1,5'd0,5'd10,2'd1,3'd4,2'd0,32'd0,DM,32'd0), eo(1,1,0,5'd10,32'h0000_7F01)});
        tbl.push_back({mk(0,0,0,1,1,2'd1,5'd0,5'd10,2'd1,3'd0,2'd0,32'd0,DM,32'd0), eo(1,1,0,5'd10,32'h80FF_7F01)});
        tbl.push_back({mk(0,0,0,1,1,2'd2,5'd0,5'd4,2'd2,3'd0,2'd0,32'd0,32'd0,32'h0040_0008), eo(1,1,0,5'd31,32'h0040_0008)});
        tbl.push_back({mk(0,0,0,1,1,2'd0,5'd0,5'd4,2'd0,3'd0,2'd0,32'hDEAD,32'd0,32'd0), eo(1,0,0,5'd0,32'h0000_DEAD)});
        tbl.push_back({mk(0,0,0,1,1,2'd1,5'd0,5'd10,2'd1,3'd3,2'd1,32'd0,DM,32'd0), eo(1,0,1,5'd10,DM)});
        tbl.push_back({mk(0,0,0,0,1,2'd1,5'd0,5'd11,2'd0,3'd0,2'd0,32'h5,32'd0,32'd0), eo(0,0,0,5'd10,DM)});
        tbl.push_back({mk(0,0,0,1,1,2'd1,5'd0,5'd12,2'd3,3'd0,2'd0,32'h77,32'd0,32'd0), eo(1,0,1,5'd12,32'h77)});
        tbl.push_back({mk(0,0,0,1,0,2'd1,5'd0,5'd13,2'd3,3'd0,2'd0,32'h88,32'd0,32'd0), eo(1,0,0,5'd13,32'h88)});
        tbl.push_back({mk(0,0,0,1,1,2'd3,5'd2,5'd3,2'd0,3'd0,2'd0,32'h99,32'd0,32'd0), eo(1,0,1,5'd0,32'h99)});
        tbl.push_back({mk(0,0,0,1,1,2'd1,5'd0,5'd3,2'd1,3'd5,2'd0,32'd0,32'h1234_5678,32'd0), eo(1,0,1,5'd3,32'h1234_5678)});
        tbl.push_back({mk(0,0,0,1,1,2'd1,5'd0,5'd4,2'd1,3'd2,2'd1,32'd0,DM,32'd0), eo(1,1,0,5'd4,32'h0000_007F)});
        tbl.push_back({mk(0,0,0,1,1,2'd1,5'd0,5'd4,2'd1,3'd0,2'd2,32'd0,DM,32'd0), eo(1,0,1,5'd4,DM)});

        for (int k = 0; k < tbl.size(); k++) step($sformatf("vec%0d", k), tbl[k].i, tbl[k].o);

        // Stall holds a captured write while inputs move
        step("stall_cap", mk(0,0,0,1,1,2'd1,5'd0,5'd5,2'd0,3'd0,2'd0,32'hAAAA_AAAA,32'd0,32'd0), eo(1,1,0,5'd5,32'hAAAA_AAAA));
        for (int k = 0; k < 3; k++)
            step($sformatf("stall_hold%0d", k), mk(0,1,0,1,1,2'd1,5'd0,5'd6,2'd0,3'd0,2'd0,32'h5555_5555,32'd0,32'd0),
                 eo(1,1,0,5'd5,32'hAAAA_AAAA));
        step("stall_rel", mk(0,0,0,1,1,2'd1,5'd0,5'd6,2'd0,3'd0,2'd0,32'h5555_5555,32'd0,32'd0), eo(1,1,0,5'd6,32'h5555_5555));

        // sel_err is held, not re-pulsed, under stall
        step("err_cap", mk(0,0,0,1,1,2'd1,5'd0,5'd8,2'd3,3'd0,2'd0,32'h1,32'd0,32'd0), eo(1,0,1,5'd8,32'h1));
        step("err_hold", mk(0,1,0,1,1,2'd1,5'd0,5'd9,2'd0,3'd0,2'd0,32'h2,32'd0,32'd0), eo(1,0,1,5'd8,32'h1));
        step("err_drop", mk(0,0,0,0,1,2'd1,5'd0,5'd9,2'd0,3'd0,2'd0,32'h2,32'd0,32'd0), eo(0,0,0,5'd8,32'h1));

        // Flush beats stall; reset discards a stalled instruction
        step("flush_stall", mk(0,1,1,1,1,2'd1,5'd0,5'd7,2'd0,3'd0,2'd0,32'h1111,32'd0,32'd0), eo(0,0,0,5'd0,32'd0));
        step("rst_cap", mk(0,0,0,1,1,2'd1,5'd0,5'd7,2'd0,3'd0,2'd0,32'h1111,32'd0,32'd0), eo(1,1,0,5'd7,32'h1111));
        step("rst_held", mk(0,1,0,1,1,2'd1,5'd0,5'd9,2'd0,3'd0,2'd0,32'h2222,32'd0,32'd0), eo(1,1,0,5'd7,32'h1111));
        step("rst_stall", mk(1,1,0,1,1,2'd1,5'd0,5'd9,2'd0,3'd0,2'd0,32'h2222,32'd0,32'd0), eo(0,0,0,5'd0,32'd0));
        step("rst_after", mk(0,1,0,1,1,2'd1,5'd0,5'd9,2'd0,3'd0,2'd0,32'h2222,32'd0,32'd0), eo(0,0,0,5'd0,32'd0));
        step("rst_idle", mk(0,0,0,0,1,2'd1,5'd0,5'd9,2'd0,3'd0,2'd0,32'h2222,32'd0,32'd0), eo(0,0,0,5'd0,32'd0));

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            ri = mk(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                    1'($urandom), 1'($urandom), 2'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                    5'($urandom), 2'($urandom), 3'($urandom_range(0, 7)), 2'($urandom),
                    $urandom, $urandom, $urandom);
            re = model_next(ri, model);
            step($sformatf("rand%0d", n), ri, re);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
